// File: rtl/stream_rr_mux.sv
// stream_rr_mux -- N-to-1 valid/ready stream multiplexer with round-robin
// arbitration and packet locking. Once a channel is granted it owns the
// output until its last beat is accepted, so packets never interleave.
// The output beat is registered (one-deep skid-free register).
//
// Build option:
//   STREAM_RR_MUX_PRIO_EN -- adds prio_mask; in IDLE, valid channels with
//                            their mask bit set win over all others.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data             NUM_IN packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid/in_last    per-channel beat valid / end-of-packet
//   in_ready            per-channel accept (only the granted channel)
//   out_data/valid/last registered output beat
//   out_src             channel that produced the current output beat
//   out_ready           downstream accept
//   prio_mask           (STREAM_RR_MUX_PRIO_EN only) priority channels

// Per-channel slice: ready/accept for one input lane.
module stream_rr_mux_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic             lock_open,  // LOCK, not in reset, output can take a beat
  input  logic [SEL_W-1:0] grant,
  output logic             ready,
  output logic             acc
);
  localparam logic [SEL_W-1:0] ID = IDX[SEL_W-1:0];

  assign ready = lock_open & (grant == ID);
  assign acc   = ready & valid;
endmodule

module stream_rr_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
`ifdef STREAM_RR_MUX_PRIO_EN
  ,
  input  logic [NUM_IN-1:0]       prio_mask
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state;
  logic [SEL_W-1:0]    grant, rr_ptr, arb_idx, nxt_ptr;
  logic                arb_found, lock_open, accept, sel_last;
  logic [NUM_IN-1:0]   pmask, req_sel, acc_v;
  logic [WIDTH-1:0]    sel_data;

`ifdef STREAM_RR_MUX_PRIO_EN
  assign pmask = prio_mask;
`else
  assign pmask = '0;
`endif

  // Priority channels narrow the request set only when at least one of
  // them is actually valid; otherwise plain round-robin over all valids.
  assign req_sel = (|(in_valid & pmask)) ? (in_valid & pmask) : in_valid;

  // Reset gates ready combinationally so nothing is accepted in a reset cycle.
  assign lock_open = (state == LOCK) & ~rst & (~out_valid | out_ready);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    stream_rr_mux_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .valid     (in_valid[i]),
      .lock_open (lock_open),
      .grant     (grant),
      .ready     (in_ready[i]),
      .acc       (acc_v[i])
    );
  end

  assign accept = |acc_v;

  // Granted channel's beat.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == i[SEL_W-1:0]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Round-robin scan: rr_ptr, rr_ptr+1, ... wrapping at NUM_IN (not 2**SEL_W).
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!arb_found && req_sel[idx]) begin
        arb_found = 1'b1;
        arb_idx   = idx[SEL_W-1:0];
      end
    end
  end

  assign nxt_ptr = (int'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      // Output register: load on accept, drain when downstream takes it.
      if (accept) begin
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_src   <= grant;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            state <= LOCK;
          end
        end
        LOCK: begin
          // Held until the last beat; a stalled source just waits here.
          if (accept && sel_last) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_mux.sv
module tb_stream_rr_mux;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, NUM_IN=4
  logic             rst;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid, in_last, in_ready;
  logic [W-1:0]     out_data;
  logic             out_valid, out_last, out_ready;
  logic [S-1:0]     out_src;
  logic [N-1:0]     prio_mask;

  // Non-power-of-two instance, NUM_IN=3
  logic             rst3;
  logic [3*W-1:0]   in_data3;
  logic [2:0]       in_valid3, in_last3, in_ready3;
  logic [W-1:0]     out_data3;
  logic             out_valid3, out_last3, out_ready3;
  logic [1:0]       out_src3;
  logic [2:0]       prio_mask3;

  stream_rr_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
`ifdef STREAM_RR_MUX_PRIO_EN
    , .prio_mask(prio_mask)
`endif
  );

  stream_rr_mux #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
    .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_last(out_last3), .out_src(out_src3),
    .out_ready(out_ready3)
`ifdef STREAM_RR_MUX_PRIO_EN
    , .prio_mask(prio_mask3)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d, input logic v, input logic l);
    in_data[ch*W +: W] = d;
    in_valid[ch]       = v;
    in_last[ch]        = l;
  endtask

  task automatic do_reset();
    in_valid = '0;
    in_last  = '0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  int            cnt [N];
  logic [N-1:0]  hs;
  int            src, beat;
  logic          exp_v;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '1; in_last = '1; out_ready = 1'b1;
    prio_mask = '0;
    rst3 = 1'b1; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;
    prio_mask3 = '0;

    // ---- reset with all channels valid ----
    step(); step();
    chk("rst_vld",   out_valid, 0);
    chk("rst_rdy",   in_ready,  0);
    chk("rst_src",   out_src,   0);
    chk("rst_data",  out_data,  0);
    rst = 1'b0;
    step();
    chk("rst_first_grant", in_ready, 4'b0001);
    step();
    chk("rst_first_vld", out_valid, 1);
    chk("rst_first_src", out_src,   0);
    in_valid = '0;

    // ---- fairness: all channels streaming 2-beat packets ----
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      set_ch(i, W'(16 * i), 1'b1, 1'b0);
    end
    hs = in_ready & in_valid;
    for (int k = 1; k <= 15; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) cnt[i] = 1 - cnt[i];
        set_ch(i, W'(16 * i + cnt[i]), 1'b1, cnt[i] == 1);
      end
      exp_v = (k % 3 != 1);
      chk($sformatf("fair_vld_%0d", k), out_valid, exp_v);
      if (exp_v) begin
        src  = ((k - 2) / 3) % 4;
        beat = (k % 3 == 2) ? 0 : 1;
        chk($sformatf("fair_src_%0d", k),  out_src,  src);
        chk($sformatf("fair_data_%0d", k), out_data, 16 * src + beat);
        chk($sformatf("fair_last_%0d", k), out_last, beat);
      end
      hs = in_ready & in_valid;
    end
    in_valid = '0;
    step();

    // ---- backpressure on channel 2 ----
    do_reset();
    set_ch(2, 8'hA1, 1'b1, 1'b0);
    step();
    chk("bp_grant", in_ready, 4'b0100);
    step();
    chk("bp_d1",    out_data, 8'hA1);
    chk("bp_l1",    out_last, 0);
    chk("bp_s1",    out_src,  2);
    set_ch(2, 8'hA2, 1'b1, 1'b0);
    step();
    chk("bp_d2",    out_data, 8'hA2);
    chk("bp_l2",    out_last, 0);
    out_ready = 1'b0;
    set_ch(2, 8'hA3, 1'b1, 1'b1);
    #1;
    chk("bp_rdy_stall", in_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_hold_d_%0d", k), out_data, 8'hA2);
      chk($sformatf("bp_hold_v_%0d", k), out_valid, 1);
      chk($sformatf("bp_hold_r_%0d", k), in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    step();
    chk("bp_d3",    out_data,  8'hA3);
    chk("bp_l3",    out_last,  1);
    chk("bp_v3",    out_valid, 1);
    set_ch(2, 8'h00, 1'b0, 1'b0);
    step();
    chk("bp_drain", out_valid, 0);

    // ---- wrap/skip: rr_ptr=3, only channel 1 valid ----
    set_ch(1, 8'h55, 1'b1, 1'b1);
    step();
    chk("wrap_grant", in_ready, 4'b0010);
    step();
    chk("wrap_data", out_data, 8'h55);
    chk("wrap_last", out_last, 1);
    chk("wrap_src",  out_src,  1);
    set_ch(1, 8'h61, 1'b1, 1'b1);
    set_ch(2, 8'h62, 1'b1, 1'b1);
    set_ch(3, 8'h63, 1'b1, 1'b1);
    step();
    chk("wrap_ptr2", in_ready, 4'b0100);
    step();
    chk("wrap_src2",  out_src,  2);
    chk("wrap_data2", out_data, 8'h62);
    set_ch(2, 8'h00, 1'b0, 1'b0);
    step();
    chk("wrap_ptr3", in_ready, 4'b1000);
    step();
    chk("wrap_src3",  out_src,  3);
    chk("wrap_data3", out_data, 8'h63);
    in_valid = '0;
    in_last  = '0;

    // ---- mid-packet gap, then reset ----
    set_ch(0, 8'h11, 1'b1, 1'b0);
    set_ch(1, 8'h22, 1'b1, 1'b0);
    step();
    chk("gap_grant", in_ready, 4'b0001);
    step();
    chk("gap_data", out_data, 8'h11);
    chk("gap_src",  out_src,  0);
    chk("gap_last", out_last, 0);
    set_ch(0, 8'h11, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("gap_lock_%0d", k), in_ready, 4'b0001);
      chk($sformatf("gap_vld_%0d", k),  out_valid, 0);
    end
    rst = 1'b1;
    step();
    chk("gap_rst_vld",  out_valid, 0);
    chk("gap_rst_data", out_data,  0);
    chk("gap_rst_last", out_last,  0);
    chk("gap_rst_src",  out_src,   0);
    chk("gap_rst_rdy",  in_ready,  0);
    rst = 1'b0;
    in_valid = '0;
    #1;
    chk("gap_idle_rdy", in_ready, 0);

`ifdef STREAM_RR_MUX_PRIO_EN
    // ---- priority mask ----
    do_reset();
    prio_mask = 4'b1000;
    set_ch(0, 8'h30, 1'b1, 1'b1);
    set_ch(3, 8'h33, 1'b1, 1'b1);
    step();
    chk("prio_grant3", in_ready, 4'b1000);
    step();
    chk("prio_src3", out_src, 3);
    set_ch(3, 8'h00, 1'b0, 1'b0);
    step();
    chk("prio_grant0", in_ready, 4'b0001);
    step();
    chk("prio_src0",  out_src,  0);
    chk("prio_data0", out_data, 8'h30);
    in_valid = '0;
    prio_mask = '0;
`endif

    // ---- NUM_IN=3: wrap from channel 2 back to 0 ----
    rst3      = 1'b0;
    in_data3  = {8'hC2, 8'hC1, 8'hC0};
    in_last3  = 3'b111;
    in_valid3 = 3'b100;
    step();
    chk("n3_grant2", in_ready3, 3'b100);
    step();
    chk("n3_src2",  out_src3,  2);
    chk("n3_data2", out_data3, 8'hC2);
    in_valid3 = 3'b011;
    step();
    chk("n3_wrap0", in_ready3, 3'b001);
    step();
    chk("n3_src0",  out_src3,  0);
    in_valid3 = 3'b101;
    step();
    chk("n3_ptr1", in_ready3, 3'b100);
    in_valid3 = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_rr_mux.md
Name: stream_rr_mux

Overview:
- Parametrised N-to-1 streaming multiplexer. Successor to the combinational 2:1 data mux.
- Merges NUM_IN valid/ready byte/word streams (e.g. per-feed order or quote messages) into one output stream.
- Uses round-robin arbitration with packet locking: a granted input keeps the output until its last beat, so messages never interleave.
- Output is registered and sits between feed parsers and the order-book/strategy pipeline.

Parameters:
- WIDTH, 8, data width per input in bits.
- NUM_IN, 4, number of input streams (2..16).
- SEL_W, 2, width of the source index; must equal ceil(log2(NUM_IN)), minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NUM_IN*WIDTH  packed input data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel beat valid.
- in_last  input  NUM_IN  per-channel end-of-packet marker, qualified by in_valid.
- in_ready  output  NUM_IN  per-channel beat accept.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_last  output  1  registered end-of-packet.
- out_src  output  SEL_W  index of the channel that produced the current out beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0.
  - state=IDLE, grant=0, rr_ptr=0.
  - rst overrides all other activity in that cycle.
  - A packet in flight when reset is asserted is dropped; no partial-packet recovery.
- States: IDLE, LOCK.
- IDLE:
  - in_ready all 0.
  - If any in_valid is 1, grant is set to the first channel with in_valid=1, scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_IN-1, 0, ...).
  - Transition to LOCK on that edge.
  - If no in_valid is 1, stay in IDLE.
- LOCK:
  - in_ready[grant] = (!out_valid | out_ready). All other in_ready bits are 0.
  - A beat is accepted when in_valid[grant] & in_ready[grant].
  - On accept, the next edge loads out_data=in_data[grant], out_last=in_last[grant], out_src=grant, out_valid=1.
  - On accept with in_last[grant]=1: go to IDLE and set rr_ptr=(grant+1) mod NUM_IN. The wrap must be correct when NUM_IN is not a power of 2.
- Output register:
  - If out_valid=1 and out_ready=0, out_data, out_last and out_src hold stable and no new beat is accepted.
  - If out_valid=1, out_ready=1 and no accept that cycle, out_valid goes to 0 next edge.
  - Accept and drain in the same cycle gives back-to-back beats.
- Latency and throughput:
  - Accept to out_valid: 1 cycle.
  - Within a packet: 1 beat/clk when out_ready=1.
  - Between packets: exactly one arbitration bubble cycle (the IDLE cycle).
- Boundary conditions:
  - A single-beat packet (valid and last on the first beat) is legal: LOCK lasts one accepting cycle.
  - in_valid on non-granted channels is ignored until the next IDLE.
  - Granted channel dropping in_valid mid-packet: stay in LOCK and wait indefinitely.
  - in_last without in_valid has no effect.
  - NUM_IN=2 with SEL_W=1 must be supported.

Optional Feature:
- Macro: STREAM_RR_MUX_PRIO_EN.
- Defined:
  - Adds input port prio_mask [NUM_IN].
  - In IDLE, if any (in_valid & prio_mask) bit is set, the round-robin scan considers only those channels. Otherwise it uses normal round-robin.
  - rr_ptr updates identically.
  - prio_mask has no effect in LOCK; a locked packet is never pre-empted.
- Undefined: no prio_mask port; pure round-robin.

Test Plan:
- Reset: rst=1 for 2 clk with all in_valid=1 -> out_valid=0, in_ready=0000, out_src=0; first grant after release is channel 0.
- Fairness: NUM_IN=4, all channels continuously offering 2-beat packets, out_ready=1 -> out_src sequence 0,0,1,1,2,2,3,3,0,0...; one bubble cycle between packets; no interleaving.
- Backpressure: channel 2 sends a 3-beat packet 0xA1,0xA2,0xA3; out_ready=0 for 3 cycles on beat 2 -> out_data holds 0xA2, in_ready[2]=0 while stalled; all 3 beats delivered in order with out_last only on 0xA3.
- Wrap/skip: rr_ptr=3, only channel 1 valid with single-beat 0x55 last=1 -> grant=1, out_data=0x55, out_last=1, rr_ptr becomes 2.
- Mid-packet gap and reset: channel 0 sends beat 0x11, then in_valid[0]=0 for 4 cycles while channel 1 is valid -> remains locked to 0, in_ready[1]=0. Then rst=1 -> all outputs return to reset values.
- With STREAM_RR_MUX_PRIO_EN: rr_ptr=0, channels 0 and 3 valid, prio_mask=1000 -> channel 3 granted first, channel 0 next.
